// File: rtl/xspi_pkg.sv
// Shared constants for the xSPI command sequencer: opcodes, lane modes, FSM states,
// per-opcode dummy counts and the decoded-command record. Octal entries need XSPI_CMD_OCTAL_EN.
package xspi_pkg;

    localparam logic [7:0] OP_FAST_READ    = 8'h0B;
    localparam logic [7:0] OP_QUAD_IO_READ = 8'hEB;
    localparam logic [7:0] OP_PP           = 8'h02;
    localparam logic [7:0] OP_QUAD_PP      = 8'h32;
    localparam logic [7:0] OP_RDSR         = 8'h05;
    localparam logic [7:0] OP_WREN         = 8'h06;

    localparam logic [4:0] DUMMY_FAST_READ    = 5'd8;
    localparam logic [4:0] DUMMY_QUAD_IO_READ = 5'd6;

`ifdef XSPI_CMD_OCTAL_EN
    localparam logic [7:0] OP_OCTAL_IO_READ    = 8'hCB;
    localparam logic [7:0] OP_OCTAL_PP         = 8'hC2;
    localparam logic [4:0] DUMMY_OCTAL_IO_READ = 5'd16;
`endif

    typedef enum logic [1:0] {
        MODE_SPI  = 2'b00,
        MODE_DSPI = 2'b01,
        MODE_QSPI = 2'b10,
        MODE_OSPI = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_IGNORE
    } state_e;

    // data_dir: 1 = sequencer drives the host (read), 0 = host sends data (program).
    typedef struct packed {
        logic       valid;
        logic       has_addr;
        mode_e      addr_mode;
        logic [4:0] dummy;
        mode_e      data_mode;
        logic       data_dir;
        logic       is_wren;
    } cmd_info_t;

endpackage

// File: rtl/xspi_cmd_seq_if.sv
// Sequencer bus: PHY transaction controls on one side, flash-core requests on the other.
interface xspi_cmd_seq_if #(
    parameter int ADDR_BITS        = 24,
    parameter int WORD_SIZE        = 32,
    parameter int CYCLE_COUNT_BITS = 6
) ();
    logic [CYCLE_COUNT_BITS-1:0] txnbc_o;
    logic [1:0]                  txnmode_o;
    logic                        txndir_o;
    logic [WORD_SIZE-1:0]        txndata_o;
    logic                        txndone_i;
    logic [WORD_SIZE-1:0]        txndata_i;
    logic [ADDR_BITS-1:0]        addr_o;
    logic                        rd_req_o;
    logic [WORD_SIZE-1:0]        rdata_i;
    logic                        wr_valid_o;
    logic [WORD_SIZE-1:0]        wdata_o;
    logic [7:0]                  status_i;
    logic                        wel_o;
    logic                        cmd_err_o;

    modport master (
        output txnbc_o, txnmode_o, txndir_o, txndata_o,
        output addr_o, rd_req_o, wr_valid_o, wdata_o, wel_o, cmd_err_o,
        input  txndone_i, txndata_i, rdata_i, status_i
    );

    modport slave (
        input  txnbc_o, txnmode_o, txndir_o, txndata_o,
        input  addr_o, rd_req_o, wr_valid_o, wdata_o, wel_o, cmd_err_o,
        output txndone_i, txndata_i, rdata_i, status_i
    );
endinterface

// File: rtl/xspi_cmd_decode.sv
// Combinational opcode decoder; octal opcodes decode only with XSPI_CMD_OCTAL_EN defined.
module xspi_cmd_decode
    import xspi_pkg::*;
(
    input  logic [7:0] i_opcode,
    output cmd_info_t  o_info
);
    always_comb begin
        o_info = '0;
        case (i_opcode)
            OP_FAST_READ: begin
                o_info.valid = 1'b1; o_info.has_addr = 1'b1; o_info.addr_mode = MODE_SPI;
                o_info.dummy = DUMMY_FAST_READ; o_info.data_mode = MODE_SPI; o_info.data_dir = 1'b1;
            end
            OP_QUAD_IO_READ: begin
                o_info.valid = 1'b1; o_info.has_addr = 1'b1; o_info.addr_mode = MODE_QSPI;
                o_info.dummy = DUMMY_QUAD_IO_READ; o_info.data_mode = MODE_QSPI; o_info.data_dir = 1'b1;
            end
            OP_PP: begin
                o_info.valid = 1'b1; o_info.has_addr = 1'b1; o_info.data_mode = MODE_SPI;
            end
            OP_QUAD_PP: begin
                o_info.valid = 1'b1; o_info.has_addr = 1'b1; o_info.data_mode = MODE_QSPI;
            end
            OP_RDSR: begin
                o_info.valid = 1'b1; o_info.data_dir = 1'b1;
            end
            OP_WREN: begin
                o_info.valid = 1'b1; o_info.is_wren = 1'b1;
            end
`ifdef XSPI_CMD_OCTAL_EN
            OP_OCTAL_IO_READ: begin
                o_info.valid = 1'b1; o_info.has_addr = 1'b1; o_info.addr_mode = MODE_OSPI;
                o_info.dummy = DUMMY_OCTAL_IO_READ; o_info.data_mode = MODE_OSPI; o_info.data_dir = 1'b1;
            end
            OP_OCTAL_PP: begin
                o_info.valid = 1'b1; o_info.has_addr = 1'b1; o_info.data_mode = MODE_OSPI;
            end
`endif
            default: o_info = '0;
        endcase
    end
endmodule

// File: rtl/xspi_cmd_seq.sv
// xSPI NOR command sequencer clocked on the SPI clock falling edge; rst_ni is chip-enable.
// Octal commands (0xCB, 0xC2) are supported only when XSPI_CMD_OCTAL_EN is defined.
module xspi_cmd_seq
    import xspi_pkg::*;
#(
    parameter int ADDR_BITS        = 24,
    parameter int WORD_SIZE        = 32,
    parameter int CYCLE_COUNT_BITS = 6
) (
    input  logic           sck_i,
    input  logic           rst_ni,
    input  logic           por_ni,
    xspi_cmd_seq_if.master bus
);
    localparam logic [ADDR_BITS-1:0]        ADDR_STEP = ADDR_BITS'(4);
    localparam logic [CYCLE_COUNT_BITS-1:0] BC_BYTE   = CYCLE_COUNT_BITS'(8);
    localparam logic [CYCLE_COUNT_BITS-1:0] BC_ADDR   = CYCLE_COUNT_BITS'(ADDR_BITS);
    localparam logic [CYCLE_COUNT_BITS-1:0] BC_WORD   = CYCLE_COUNT_BITS'(WORD_SIZE);

    cmd_info_t                   w_dec;
    state_e                      r_state, w_state;
    logic [CYCLE_COUNT_BITS-1:0] r_bc, w_bc;
    mode_e                       r_mode, w_mode, r_data_mode, w_data_mode;
    logic                        r_dir, w_dir;
    logic [WORD_SIZE-1:0]        r_txdata, w_txdata, r_wdata, w_wdata, w_status_word;
    logic [ADDR_BITS-1:0]        r_addr, w_addr;
    logic                        r_rd_req, w_rd_req, r_wr_valid, w_wr_valid;
    logic                        r_err, w_err, r_wel, w_wel;
    logic [4:0]                  r_dummy, w_dummy;
    logic                        r_read, w_read, r_rdsr, w_rdsr;

    xspi_cmd_decode u_decode (
        .i_opcode (bus.txndata_i[7:0]),
        .o_info   (w_dec)
    );

    assign w_status_word = {(WORD_SIZE / 8){bus.status_i}};

    always_comb begin
        // NOTE: every next value defaults to its register first, so no path leaves a latch.
        w_state = r_state;   w_bc = r_bc;         w_mode = r_mode;       w_dir = r_dir;
        w_txdata = r_txdata; w_wdata = r_wdata;   w_addr = r_addr;       w_err = r_err;
        w_wel = r_wel;       w_dummy = r_dummy;   w_data_mode = r_data_mode;
        w_read = r_read;     w_rdsr = r_rdsr;     w_rd_req = 1'b0;       w_wr_valid = 1'b0;
        // A program word is reported at its own address; the step follows one cycle later.
        if (r_wr_valid) w_addr = r_addr + ADDR_STEP;
        if (bus.txndone_i) begin
            unique case (r_state)
                ST_CMD: begin
                    w_dummy = w_dec.dummy;  w_data_mode = w_dec.data_mode;  w_read = w_dec.data_dir;
                    w_rdsr  = w_dec.valid && !w_dec.has_addr && !w_dec.is_wren;
                    if (!w_dec.valid || (w_dec.has_addr && !w_dec.data_dir && !r_wel)) begin
                        w_err = 1'b1;  w_state = ST_IGNORE;
                    end else if (w_dec.is_wren) begin
                        w_wel = 1'b1;  w_state = ST_IGNORE;
                    end else if (w_dec.has_addr) begin
                        w_state = ST_ADDR;  w_bc = BC_ADDR;  w_mode = w_dec.addr_mode;
                    end else begin
                        w_state = ST_DATA;  w_bc = BC_BYTE;  w_mode = MODE_SPI;
                        w_dir = 1'b1;       w_txdata = w_status_word;
                    end
                end
                ST_ADDR: begin
                    w_addr = {bus.txndata_i[ADDR_BITS-1:2], 2'b00};
                    if (r_read) begin
                        w_rd_req = 1'b1;  w_state = ST_DUMMY;
                        w_bc = CYCLE_COUNT_BITS'(r_dummy);  w_mode = MODE_SPI;
                    end else begin
                        w_state = ST_DATA;  w_bc = BC_WORD;  w_mode = r_data_mode;
                    end
                end
                ST_DUMMY: begin
                    // First word leaves with the dummy edge; addr_o then points at the prefetch.
                    w_txdata = bus.rdata_i;  w_addr = r_addr + ADDR_STEP;  w_rd_req = 1'b1;
                    w_state = ST_DATA;  w_bc = BC_WORD;  w_mode = r_data_mode;  w_dir = 1'b1;
                end
                ST_DATA: begin
                    if (r_rdsr) begin
                        w_txdata = w_status_word;
                    end else if (r_read) begin
                        w_txdata = bus.rdata_i;  w_addr = r_addr + ADDR_STEP;  w_rd_req = 1'b1;
                    end else begin
                        // WEL drops with the first committed word, so it is already low after CE.
                        w_wdata = bus.txndata_i;  w_wr_valid = 1'b1;  w_wel = 1'b0;
                    end
                end
                default: w_state = r_state;
            endcase
        end
    end

    always_ff @(negedge sck_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_CMD;   r_bc <= BC_BYTE;   r_mode <= MODE_SPI;   r_dir <= 1'b0;
            r_txdata <= '0;      r_wdata <= '0;     r_addr <= '0;         r_err <= 1'b0;
            r_rd_req <= 1'b0;    r_wr_valid <= 1'b0;
            r_dummy <= '0;       r_data_mode <= MODE_SPI;  r_read <= 1'b0;  r_rdsr <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values of its neighbours.
            r_state <= w_state;  r_bc <= w_bc;      r_mode <= w_mode;     r_dir <= w_dir;
            r_txdata <= w_txdata; r_wdata <= w_wdata; r_addr <= w_addr;   r_err <= w_err;
            r_rd_req <= w_rd_req; r_wr_valid <= w_wr_valid;
            r_dummy <= w_dummy;  r_data_mode <= w_data_mode;  r_read <= w_read;  r_rdsr <= w_rdsr;
        end
    end

    // WEL survives chip-enable cycles and only updates while the device is selected.
    always_ff @(negedge sck_i or negedge por_ni) begin
        if (!por_ni)     r_wel <= 1'b0;
        else if (rst_ni) r_wel <= w_wel;
    end

    assign bus.txnbc_o    = r_bc;
    assign bus.txnmode_o  = r_mode;
    assign bus.txndir_o   = r_dir;
    assign bus.txndata_o  = r_txdata;
    assign bus.addr_o     = r_addr;
    assign bus.rd_req_o   = r_rd_req;
    assign bus.wr_valid_o = r_wr_valid;
    assign bus.wdata_o    = r_wdata;
    assign bus.wel_o      = r_wel;
    assign bus.cmd_err_o  = r_err;
endmodule

// File: tb/tb_xspi_cmd_seq.sv
// Self-checking bench: the bench plays PHY, host and flash core; expectations come from a
// per-opcode command table and plain address arithmetic.
module tb_xspi_cmd_seq;
    import xspi_pkg::*;

    localparam int AB = 24;
    localparam int WS = 32;
    localparam int CB = 6;
    localparam int unsigned AMASK = (1 << AB) - 1;
    localparam int K_BAD = 0, K_READ = 1, K_WRITE = 2, K_RDSR = 3, K_WREN = 4;

    typedef struct {
        int kind;
        int alanes;
        int dummy;
        int dlanes;
    } props_t;

    logic sck = 1'b0;
    logic rst_ce_n = 1'b0;
    logic por_n = 1'b0;
    always #5 sck = ~sck;

    xspi_cmd_seq_if #(.ADDR_BITS(AB), .WORD_SIZE(WS), .CYCLE_COUNT_BITS(CB)) bus ();

    xspi_cmd_seq #(.ADDR_BITS(AB), .WORD_SIZE(WS), .CYCLE_COUNT_BITS(CB)) dut (
        .sck_i  (sck),
        .rst_ni (rst_ce_n),
        .por_ni (por_n),
        .bus    (bus)
    );

    // Flash core: combinational read path, word value derived from its address.
    assign bus.rdata_i = 32'hA5A50000 + WS'(bus.addr_o);

    int checks = 0;
    int failures = 0;
    bit m_wel = 1'b0;
    int unsigned rd_q[$];
    logic [55:0] wr_q[$];
    logic [WS-1:0] wr_src[$];

    always @(posedge sck) begin
        if (bus.rd_req_o)   rd_q.push_back(int'(bus.addr_o));
        if (bus.wr_valid_o) wr_q.push_back({bus.addr_o, bus.wdata_o});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic props_t props(input logic [7:0] op);
        props_t p;
        p = '{K_BAD, 0, 0, 0};
        case (op)
            8'h0B: p = '{K_READ, 1, 8, 1};
            8'hEB: p = '{K_READ, 4, 6, 4};
            8'h02: p = '{K_WRITE, 1, 0, 1};
            8'h32: p = '{K_WRITE, 1, 0, 4};
            8'h05: p = '{K_RDSR, 0, 0, 1};
            8'h06: p = '{K_WREN, 0, 0, 0};
`ifdef XSPI_CMD_OCTAL_EN
            8'hCB: p = '{K_READ, 8, 16, 8};
            8'hC2: p = '{K_WRITE, 1, 0, 8};
`endif
            default: p = '{K_BAD, 0, 0, 0};
        endcase
        return p;
    endfunction

    function automatic logic [1:0] mode_of(input int lanes);
        case (lanes)
            2:       return 2'b01;
            4:       return 2'b10;
            8:       return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // One PHY word: sample the requested transaction, clock it, raise done on the last cycle.
    task automatic phy_word(input logic [WS-1:0] host, output logic [CB-1:0] bc,
                            output logic [1:0] md, output logic dir, output logic [WS-1:0] out);
        int lanes, cyc;
        bc = bus.txnbc_o;  md = bus.txnmode_o;  dir = bus.txndir_o;  out = bus.txndata_o;
        lanes = 1 << md;
        cyc = (int'(bc) + lanes - 1) / lanes;
        if (cyc < 1) cyc = 1;
        for (int i = 0; i < cyc; i++) begin
            @(posedge sck);
            if (i == cyc - 1) begin
                bus.txndone_i = 1'b1;
                bus.txndata_i = host;
            end
            @(negedge sck);
            #1;
            bus.txndone_i = 1'b0;
        end
    endtask

    task automatic phy_partial(input int cyc);
        for (int i = 0; i < cyc; i++) begin
            @(posedge sck);
            @(negedge sck);
            #1;
        end
    endtask

    task automatic ce_cycle();
        @(posedge sck);
        #1 rst_ce_n = 1'b0;
        @(posedge sck);
        #1 rst_ce_n = 1'b1;
        @(negedge sck);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_bc"},   bus.txnbc_o, 8);
        check({tag, "_mode"}, bus.txnmode_o, 0);
        check({tag, "_dir"},  bus.txndir_o, 0);
        check({tag, "_err"},  bus.cmd_err_o, 0);
        check({tag, "_rdq"},  bus.rd_req_o, 0);
        check({tag, "_wel"},  bus.wel_o, m_wel);
    endtask

    task automatic run_cmd(input logic [7:0] op, input logic [WS-1:0] aword, input int n,
                           input bit partial);
        props_t p;
        logic [CB-1:0] bc;
        logic [1:0] md;
        logic dir;
        logic [WS-1:0] out, d;
        logic [WS-1:0] wd[$];
        int unsigned a;
        bit exp_err;
        p = props(op);
        a = int'(aword) & AMASK & ~32'h3;
        rd_q.delete();
        wr_q.delete();
        phy_word({24'h0, op}, bc, md, dir, out);
        check("op_bc", bc, 8);
        check("op_mode", md, 0);
        check("op_dir", dir, 0);
        exp_err = (p.kind == K_BAD) || (p.kind == K_WRITE && !m_wel);
        if (p.kind == K_WREN) m_wel = 1'b1;
        check("err_after_op", bus.cmd_err_o, exp_err);
        check("wel_after_op", bus.wel_o, m_wel);
        if (exp_err || p.kind == K_WREN) begin
            phy_word($urandom, bc, md, dir, out);
            check("ign_bc", bc, 8);
            check("ign_dir", dir, 0);
        end else if (p.kind == K_RDSR) begin
            for (int k = 0; k < n; k++) begin
                phy_word($urandom, bc, md, dir, out);
                check("rdsr_bc", bc, 8);
                check("rdsr_dir", dir, 1);
                check("rdsr_word", out, {4{bus.status_i}});
            end
        end else begin
            phy_word(aword, bc, md, dir, out);
            check("addr_bc", bc, AB);
            check("addr_mode", md, mode_of(p.alanes));
            check("addr_dir", dir, 0);
            if (p.kind == K_READ) begin
                phy_word($urandom, bc, md, dir, out);
                check("dummy_bc", bc, p.dummy);
                check("dummy_mode", md, 0);
                check("dummy_dir", dir, 0);
                for (int k = 0; k < n; k++) begin
                    phy_word($urandom, bc, md, dir, out);
                    check("rd_bc", bc, WS);
                    check("rd_mode", md, mode_of(p.dlanes));
                    check("rd_dir", dir, 1);
                    check("rd_word", out, 32'hA5A50000 + ((a + 4 * k) & AMASK));
                end
            end else begin
                for (int k = 0; k < n; k++) begin
                    d = (wr_src.size() > 0) ? wr_src.pop_front() : WS'($urandom);
                    wd.push_back(d);
                    phy_word(d, bc, md, dir, out);
                    check("wr_bc", bc, WS);
                    check("wr_mode", md, mode_of(p.dlanes));
                    check("wr_dir", dir, 0);
                end
                if (partial) phy_partial(3);
                m_wel = 1'b0;
            end
        end
        @(posedge sck);
        #1;
        if (p.kind == K_READ && !exp_err)
            check("rd_req_addr", (rd_q.size() > 0) ? rd_q[0] : 32'hFFFF_FFFF, a);
        else
            check("rd_req_none", rd_q.size(), 0);
        if (p.kind == K_WRITE && !exp_err) begin
            check("wr_count", wr_q.size(), n);
            for (int k = 0; k < n && k < wr_q.size(); k++) begin
                check("wr_addr", wr_q[k][55:32], (a + 4 * k) & AMASK);
                check("wr_data", wr_q[k][31:0], wd[k]);
            end
        end else begin
            check("wr_none", wr_q.size(), 0);
        end
        ce_cycle();
        check_idle("post_ce");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [CB-1:0] bc;
        logic [1:0] md;
        logic dir;
        logic [WS-1:0] out;
        logic [7:0] ops[10];
        bus.txndone_i = 1'b0;
        bus.txndata_i = '0;
        bus.status_i  = 8'h03;
        repeat (2) @(posedge sck);
        #1;
        check("rst_bc", bus.txnbc_o, 8);
        check("rst_mode", bus.txnmode_o, 0);
        check("rst_dir", bus.txndir_o, 0);
        check("rst_txdata", bus.txndata_o, 0);
        check("rst_addr", bus.addr_o, 0);
        check("rst_wdata", bus.wdata_o, 0);
        check("rst_wvalid", bus.wr_valid_o, 0);
        check("rst_wel", bus.wel_o, 0);
        check("rst_err", bus.cmd_err_o, 0);
        por_n = 1'b1;
        rst_ce_n = 1'b1;
        @(negedge sck);
        #1;

        run_cmd(8'h0B, 32'h0000_0100, 2, 1'b0);
        run_cmd(8'h0B, 32'h00FF_FFF8, 3, 1'b0);
        run_cmd(8'h02, 32'h0000_0040, 1, 1'b0);
        run_cmd(8'h06, 32'h0, 0, 1'b0);
        wr_src.push_back(32'hDEADBEEF);
        wr_src.push_back(32'h01234567);
        run_cmd(8'h32, 32'h0000_0040, 2, 1'b1);
        bus.status_i = 8'h03;
        run_cmd(8'h05, 32'h0, 3, 1'b0);

        // Chip-enable drop halfway through a quad address phase.
        rd_q.delete();
        phy_word(32'hEB, bc, md, dir, out);
        phy_partial(3);
        @(posedge sck);
        #1;
        check("abort_rd_none", rd_q.size(), 0);
        ce_cycle();
        check_idle("abort");
        run_cmd(8'hEB, 32'h0012_3457, 2, 1'b0);
        run_cmd(8'hCB, 32'h0000_0200, 2, 1'b0);
        run_cmd(8'h06, 32'h0, 0, 1'b0);
        run_cmd(8'hC2, 32'h0000_0300, 1, 1'b0);

        ops = '{8'h0B, 8'hEB, 8'h02, 8'h32, 8'h05, 8'h06, 8'h06, 8'hCB, 8'hC2, 8'h9F};
        for (int t = 0; t < 24; t++) begin
            bus.status_i = 8'($urandom);
            run_cmd(ops[$urandom_range(9, 0)], 32'($urandom) & AMASK,
                    int'($urandom_range(3, 1)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/xspi_cmd_seq.md
Name: xspi_cmd_seq

Overview:
- NOR-flash command sequencer that sits directly downstream of the SPI slave PHY.
- Drives the PHY transaction interface (bit count, lane mode, direction, outgoing word) and consumes each completed word (txndone/txndata).
- Parses opcode → address → dummy → data phases and presents read/write requests to the flash-core side.
- Clocked on the SPI clock's falling edge, so new transaction parameters are in place at the same edge the PHY clears its cycle counter.

Parameters:
- ADDR_BITS, 24, flash address width (must be multiple of 8, ≤ 32).
- WORD_SIZE, 32, data word width; equals PHY WORD_SIZE.
- CYCLE_COUNT_BITS, 6, width of txnbc_o; equals PHY parameter.

Ports:
- sck_i  in  1  SPI clock; all flops update on falling edge.
- rst_ni  in  1  async active-low reset (top level ties to chip-enable, so CE deassert = reset).
- txnbc_o  out  CYCLE_COUNT_BITS  transaction bit count to PHY.
- txnmode_o  out  2  lane mode: 00 single, 01 dual, 10 quad, 11 octo.
- txndir_o  out  1  0 = receive from host, 1 = drive host.
- txndata_o  out  WORD_SIZE  word to shift out (used only when txndir_o = 1).
- txndone_i  in  1  PHY word-complete flag (rises on sck rising edge).
- txndata_i  in  WORD_SIZE  PHY received word, LSB-aligned.
- addr_o  out  ADDR_BITS  current byte address.
- rd_req_o  out  1  one-cycle pulse: core must present rdata_i for addr_o before dummy phase ends.
- rdata_i  in  WORD_SIZE  read data from core.
- wr_valid_o  out  1  one-cycle pulse: wdata_o is valid for addr_o.
- wdata_o  out  WORD_SIZE  program data word.
- status_i  in  8  status register value.
- wel_o  out  1  write-enable latch (set by WREN).
- cmd_err_o  out  1  sticky until reset: unsupported opcode received.

Behaviour:
- Reset values:
  - Transaction outputs: txnbc_o = 8, txnmode_o = 00, txndir_o = 0, txndata_o = 0. The first PHY transaction after CE assert is therefore the opcode byte.
  - Request and flag outputs: addr_o = 0, rd_req_o = 0, wr_valid_o = 0, wdata_o = 0, cmd_err_o = 0.
  - wel_o: cleared only by reset or a completed program command, so it must persist across CE. wel_o therefore has its own reset tie-off (rst_ni of the WEL flop tied to the global power-on reset, not to CE) and is the single exception to CE reset.
- Event definition: all actions occur on the falling edge at which txndone_i is high. This is the "done edge"; exactly one per PHY word.
- States: CMD, ADDR, DUMMY, DATA, IGNORE.
- CMD: on done edge, decode txndata_i[7:0]:
  - 0x0B FAST_READ: addr 1-lane, 8 dummy, data 1-lane out.
  - 0xEB QUAD_IO_READ: addr 4-lane, 6 dummy, data 4-lane out.
  - 0x02 PP: addr 1-lane, data 1-lane in.
  - 0x32 QUAD_PP: addr 1-lane, data 4-lane in.
  - 0x05 RDSR: no addr; DATA out, word = status_i replicated, txnbc 8, repeats until CE deassert.
  - 0x06 WREN: set wel_o, go IGNORE.
  - Other opcodes: set cmd_err_o, go IGNORE.
- ADDR:
  - txnbc_o = ADDR_BITS, txnmode_o = command's addr mode, txndir_o = 0.
  - On done edge: addr_o ← txndata_i[ADDR_BITS-1:0] with word-aligned low 2 bits forced 0.
  - Read commands pulse rd_req_o, then go DUMMY. Write commands go DATA.
- DUMMY:
  - txnbc_o = dummy count, txnmode_o = 00, txndir_o = 0.
  - On done edge: txndata_o ← rdata_i, go DATA with txndir_o = 1.
- DATA read:
  - txnbc_o = WORD_SIZE.
  - On each done edge: addr_o += 4 (wraps modulo 2^ADDR_BITS), pulse rd_req_o, txndata_o ← rdata_i (core must answer same-cycle; combinational read path or prefetched word).
- DATA write:
  - txndir_o = 0.
  - On each done edge: wdata_o ← txndata_i, wr_valid_o pulse with pre-increment addr_o, then addr_o += 4.
  - The partial final word at CE deassert is discarded.
  - On reset, if ≥ 1 word was written, clear wel_o.
  - PP with wel_o = 0: set cmd_err_o, go IGNORE, no wr_valid_o.
- IGNORE: txndir_o = 0, txnbc_o = 8; stays until reset. PHY never drives sio.
- Reset mid-phase: everything returns to CMD immediately; no pulse is emitted for the incomplete word.

Optional Feature:
- Macro: XSPI_CMD_OCTAL_EN.
- Defined: adds 0xCB OCTAL_IO_READ (addr 8-lane, 16 dummy, data 8-lane out) and 0xC2 OCTAL_PP (addr 1-lane, data 8-lane in).
- Undefined: 0xCB and 0xC2 are unsupported (cmd_err_o, IGNORE); txnmode_o never equals 11.

Decomposition:
- Shared package/include xspi_pkg:
  - Opcode constants.
  - Mode encodings (MODE_SPI/DSPI/QSPI/OSPI).
  - State encodings.
  - Per-opcode dummy counts.
- Sub-module xspi_cmd_decode:
  - Combinational opcode → {valid, has_addr, addr_mode, dummy, data_mode, data_dir}.
  - Reused by any future DDR variant.

Test Plan:
1. Reset, CE assert, host sends 0x0B, addr 0x000100, 8 dummy; rdata = addr+0xA5A50000 → rd_req at addr 0x100, host reads 0xA5A50100, then 0xA5A50104; addr wraps 0xFFFFFC→0x000000.
2. 0x06 then CE cycle, 0x32 addr 0x000040, 2 quad words 0xDEADBEEF, 0x01234567 → wr_valid twice at 0x40/0x44 with those words; txnmode_o = 10 in DATA; wel_o clears after CE.
3. 0x02 without prior WREN → cmd_err_o = 1, no wr_valid_o, txndir_o stays 0.
4. 0x05 with status_i = 0x03, 3 bytes read → host receives 0x03 ×3.
5. CE deassert mid-ADDR (12 of 24 bits) → state CMD, txnbc_o = 8, no rd_req_o; next 0xEB works normally.
6. Opcode 0xCB: with XSPI_CMD_OCTAL_EN → 16 dummy cycles, mode 11 data; without → cmd_err_o = 1.
